// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC register poller: FSM state encoding, the
// default RTC device address on the I2C bus, and the clock-halt bit position
// inside register 0.
// No ports (package).
// -----------------------------------------------------------------------------
package rtc_pkg;

    typedef enum logic [2:0] {
        POLL_WAIT = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_WAIT   = 3'd2,
        PUBLISH   = 3'd3,
        SET_ISSUE = 3'd4,
        SET_WAIT  = 3'd5
    } state_t;

    // 7-bit I2C device address of the RTC as strapped on the board.
    localparam logic [6:0] RTC_DEV_ADDR = 7'b1101000;

    // Clock-halt flag lives in the seconds register; it is not a BCD digit.
    localparam int CH_BIT_POS = 7;

endpackage

// File: rtl/rtc_done_sync.sv
// -----------------------------------------------------------------------------
// rtc_done_sync
// Delays the IIC_COR completion level through two flops and turns its rising
// edge into a single-cycle completion event.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   i_done     in   completion level from IIC_COR
//   o_done_evt out  one-cycle pulse on a rising edge of the delayed level
// -----------------------------------------------------------------------------
module rtc_done_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_done,
    output logic o_done_evt
);

    logic r_done_d1;
    logic r_done_d2;
    logic r_done_d2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_d1   <= 1'b0;
            r_done_d2   <= 1'b0;
            r_done_d2_q <= 1'b0;
        end else begin
            r_done_d1   <= i_done;
            r_done_d2   <= r_done_d1;
            r_done_d2_q <= r_done_d2;
        end
    end

    assign o_done_evt = r_done_d2 & ~r_done_d2_q;

endmodule

// File: rtl/rtc_reg_poller.sv
// -----------------------------------------------------------------------------
// rtc_reg_poller
// Periodically reads NUM_REGS consecutive RTC registers through the IIC_COR
// handshake and publishes them atomically; also performs host-requested
// time-set burst writes followed by an immediate readback. Each transaction
// is guarded by a timeout that raises a sticky error.
// Optional build macro: RTC_BCD_CHECK_EN -- rejects non-BCD register sets at
// publish time and adds the bcd_err output.
// Ports:
//   clk, rst              system clock, async active-high reset
//   set_req, set_data     pulse to write set_data (reg k at [k*DATA_W +: DATA_W])
//   set_busy              high while a set burst is pending or in progress
//   time_out, time_valid  last published register set and its update pulse
//   timeout_err, err_clr  sticky transaction-timeout flag and its clear
//   i2c_*                 IIC_COR request/response handshake
//   bcd_err               (RTC_BCD_CHECK_EN only) publish rejected, one cycle
//
// state     | meaning
// POLL_WAIT | idle, counting down the poll interval; pending set has priority
// RD_ISSUE  | present read address and pulse i2c_re_en
// RD_WAIT   | wait for completion, capture read data into the shadow buffer
// PUBLISH   | copy shadow buffer to time_out, pulse time_valid
// SET_ISSUE | present write address/data and pulse i2c_wr_en
// SET_WAIT  | wait for write completion, then next write or readback sweep
// -----------------------------------------------------------------------------
module rtc_reg_poller
    import rtc_pkg::*;
#(
    parameter int NUM_REGS    = 3,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int START_ADDR  = 0,
    parameter int POLL_CYC    = 100000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_req,
    input  logic [NUM_REGS*DATA_W-1:0] set_data,
    output logic                       set_busy,
    output logic [NUM_REGS*DATA_W-1:0] time_out,
    output logic                       time_valid,
    output logic                       timeout_err,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          i2c_addr,
    output logic                       i2c_wr_en,
    output logic                       i2c_re_en,
    output logic [DATA_W-1:0]          i2c_wdata,
    input  logic [DATA_W-1:0]          i2c_rdata,
    input  logic                       i2c_done
`ifdef RTC_BCD_CHECK_EN
    ,
    output logic                       bcd_err
`endif
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMR_W = $clog2(POLL_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [TMR_W-1:0] POLL_RELOAD = TMR_W'(POLL_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT    = TO_W'(TIMEOUT_CYC);

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [TMR_W-1:0]           r_timer;
    logic [TO_W-1:0]            r_to_cnt;
    logic [DATA_W-1:0]          r_shadow   [NUM_REGS];
    logic [DATA_W-1:0]          r_set_data [NUM_REGS];
    logic                       r_set_busy;
    logic [NUM_REGS*DATA_W-1:0] r_time_out;
    logic                       r_time_valid;
    logic                       r_err;
    logic [ADDR_W-1:0]          r_addr;
    logic [DATA_W-1:0]          r_wdata;
    logic                       r_wr_en;
    logic                       r_re_en;
    logic                       w_done_evt;
    logic [ADDR_W-1:0]          w_addr;

    rtc_done_sync u_done_sync (
        .clk        (clk),
        .rst        (rst),
        .i_done     (i2c_done),
        .o_done_evt (w_done_evt)
    );

    // Wraps modulo 2^ADDR_W by construction.
    assign w_addr = ADDR_W'(START_ADDR) + ADDR_W'(r_idx);

`ifdef RTC_BCD_CHECK_EN
    logic              r_bcd_err;
    logic              w_bcd_ok;
    logic [DATA_W-1:0] w_reg;

    always_comb begin
        w_bcd_ok = 1'b1;
        w_reg    = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_reg = r_shadow[k];
            if (k == 0)
                w_reg[CH_BIT_POS] = 1'b0;
            for (int n = 0; n < DATA_W / 4; n++)
                if (w_reg[n*4 +: 4] > 4'd9)
                    w_bcd_ok = 1'b0;
        end
    end

    assign bcd_err = r_bcd_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= POLL_WAIT;
            r_idx        <= '0;
            r_timer      <= '0;
            r_to_cnt     <= '0;
            r_set_busy   <= 1'b0;
            r_time_out   <= '0;
            r_time_valid <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr_en      <= 1'b0;
            r_re_en      <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_shadow[k]   <= '0;
                r_set_data[k] <= '0;
            end
`ifdef RTC_BCD_CHECK_EN
            r_bcd_err    <= 1'b0;
`endif
        end else begin
            r_wr_en      <= 1'b0;
            r_re_en      <= 1'b0;
            r_time_valid <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
            r_bcd_err    <= 1'b0;
`endif
            // A timeout later in this block overrides the clear.
            if (err_clr)
                r_err <= 1'b0;

            case (r_state)
                POLL_WAIT: begin
                    if (r_timer != '0)
                        r_timer <= r_timer - TMR_W'(1);
                    if (r_set_busy) begin
                        r_idx   <= '0;
                        r_state <= SET_ISSUE;
                    end else if (r_timer == '0) begin
                        r_idx   <= '0;
                        r_state <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    r_addr   <= w_addr;
                    r_re_en  <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (w_done_evt) begin
                        r_shadow[r_idx] <= i2c_rdata;
                        if (r_idx == LAST_IDX) begin
                            r_state <= PUBLISH;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= RD_ISSUE;
                        end
                    end else if (r_to_cnt == TO_LIMIT) begin
                        r_err      <= 1'b1;
                        r_set_busy <= 1'b0;
                        r_timer    <= POLL_RELOAD;
                        r_state    <= POLL_WAIT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                PUBLISH: begin
`ifdef RTC_BCD_CHECK_EN
                    if (w_bcd_ok) begin
                        for (int k = 0; k < NUM_REGS; k++)
                            r_time_out[k*DATA_W +: DATA_W] <= r_shadow[k];
                        r_time_valid <= 1'b1;
                    end else begin
                        r_bcd_err <= 1'b1;
                    end
`else
                    for (int k = 0; k < NUM_REGS; k++)
                        r_time_out[k*DATA_W +: DATA_W] <= r_shadow[k];
                    r_time_valid <= 1'b1;
`endif
                    r_timer <= POLL_RELOAD;
                    r_state <= POLL_WAIT;
                end
                SET_ISSUE: begin
                    r_addr   <= w_addr;
                    r_wdata  <= r_set_data[r_idx];
                    r_wr_en  <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= SET_WAIT;
                end
                SET_WAIT: begin
                    if (w_done_evt) begin
                        if (r_idx == LAST_IDX) begin
                            r_set_busy <= 1'b0;
                            r_idx      <= '0;
                            r_state    <= RD_ISSUE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= SET_ISSUE;
                        end
                    end else if (r_to_cnt == TO_LIMIT) begin
                        r_err      <= 1'b1;
                        r_set_busy <= 1'b0;
                        r_timer    <= POLL_RELOAD;
                        r_state    <= POLL_WAIT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: r_state <= POLL_WAIT;
            endcase

            // Placed last so a request accepted in the same cycle as an abort
            // is not lost.
            if (set_req && !r_set_busy) begin
                r_set_busy <= 1'b1;
                for (int k = 0; k < NUM_REGS; k++)
                    r_set_data[k] <= set_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign set_busy    = r_set_busy;
    assign time_out    = r_time_out;
    assign time_valid  = r_time_valid;
    assign timeout_err = r_err;
    assign i2c_addr    = r_addr;
    assign i2c_wdata   = r_wdata;
    assign i2c_wr_en   = r_wr_en;
    assign i2c_re_en   = r_re_en;

endmodule

// File: tb/tb_rtc_reg_poller.sv
module tb_rtc_reg_poller;
    localparam int NR = 3;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int SA = 0;
    localparam int PC = 100;
    localparam int TO = 64;
    localparam int AMOD = 1 << AW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             set_req = 1'b0;
    logic [NR*DW-1:0] set_data = '0;
    logic             set_busy;
    logic [NR*DW-1:0] time_out;
    logic             time_valid;
    logic             timeout_err;
    logic             err_clr = 1'b0;
    logic [AW-1:0]    i2c_addr;
    logic             i2c_wr_en;
    logic             i2c_re_en;
    logic [DW-1:0]    i2c_wdata;
    logic [DW-1:0]    i2c_rdata = '0;
    logic             i2c_done = 1'b0;
`ifdef RTC_BCD_CHECK_EN
    logic             bcd_err;
`endif

    rtc_reg_poller #(
        .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .START_ADDR(SA),
        .POLL_CYC(PC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .set_data(set_data),
        .set_busy(set_busy), .time_out(time_out), .time_valid(time_valid),
        .timeout_err(timeout_err), .err_clr(err_clr), .i2c_addr(i2c_addr),
        .i2c_wr_en(i2c_wr_en), .i2c_re_en(i2c_re_en), .i2c_wdata(i2c_wdata),
        .i2c_rdata(i2c_rdata), .i2c_done(i2c_done)
`ifdef RTC_BCD_CHECK_EN
        , .bcd_err(bcd_err)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 read request, 1 write request, 2 time_valid, 3 bcd_err
    typedef struct { int kind; int addr; int data; int cyc; } ev_t;
    ev_t log_q[$];

    logic [DW-1:0] mem [0:AMOD-1];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    bit  hang_en = 1'b0;
    int  hang_addr = 0;

    // Event monitor
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (!rst) begin
            if (i2c_re_en)  log_q.push_back('{kind:0, addr:int'(i2c_addr), data:0, cyc:cyc});
            if (i2c_wr_en)  log_q.push_back('{kind:1, addr:int'(i2c_addr), data:int'(i2c_wdata), cyc:cyc});
            if (time_valid) log_q.push_back('{kind:2, addr:0, data:0, cyc:cyc});
`ifdef RTC_BCD_CHECK_EN
            if (bcd_err)    log_q.push_back('{kind:3, addr:0, data:0, cyc:cyc});
`endif
        end
    end

    // RTC device + IIC_COR behavioural model: done drops on a request and
    // rises again after a random latency, staying high until the next request.
    initial begin
        int  cnt;
        bit  pend;
        int  a;
        cnt = 0; pend = 0; a = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                i2c_done = 1'b0;
                pend = 0;
            end else if (i2c_re_en || i2c_wr_en) begin
                i2c_done = 1'b0;
                a = int'(i2c_addr);
                if (i2c_wr_en) mem[a] = i2c_wdata;
                pend = !(hang_en && i2c_re_en && a == hang_addr);
                cnt = int'($urandom_range(1, 4));
            end else if (pend) begin
                if (cnt == 0) begin
                    i2c_rdata = mem[a];
                    i2c_done = 1'b1;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NR*DW-1:0] model_time();
        logic [NR*DW-1:0] r;
        for (int k = 0; k < NR; k++) r[k*DW +: DW] = mem[(SA + k) % AMOD];
        return r;
    endfunction

    function automatic int find_ev(input int kind, input int nth);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].kind == kind) begin
            n++;
            if (n == nth) return i;
        end
        return -1;
    endfunction

    // Reads in [from,upto) must be exactly one sweep over SA..SA+NR-1.
    function automatic bit sweep_ok(input int from, input int upto);
        int k = 0;
        for (int i = from; i < upto && i < log_q.size(); i++) if (log_q[i].kind == 0) begin
            if (k >= NR || log_q[i].addr != (SA + k) % AMOD) return 0;
            k++;
        end
        return k == NR;
    endfunction

    // Writes in [from,upto) must be exactly one burst carrying d.
    function automatic bit burst_ok(input int from, input int upto, input logic [NR*DW-1:0] d);
        int k = 0;
        for (int i = from; i < upto && i < log_q.size(); i++) if (log_q[i].kind == 1) begin
            if (k >= NR || log_q[i].addr != (SA + k) % AMOD || log_q[i].data != int'(d[k*DW +: DW])) return 0;
            k++;
        end
        return k == NR;
    endfunction

    task automatic wait_ev(input int kind, input int nth, input int bound, output int idx);
        idx = -1;
        for (int c = 0; c < bound && idx < 0; c++) begin
            @(negedge clk);
            idx = find_ev(kind, nth);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (time_out !== '0) begin n_err++; $display("FAIL reset_time_out got %h need 0", time_out); end
        n_cmp++; if ({time_valid, set_busy, timeout_err, i2c_wr_en, i2c_re_en} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got %b need 00000", {time_valid, set_busy, timeout_err, i2c_wr_en, i2c_re_en}); end
        n_cmp++; if ({i2c_addr, i2c_wdata} !== '0) begin n_err++; $display("FAIL reset_bus got %h/%h need 0/0", i2c_addr, i2c_wdata); end
    endtask

    task automatic test_power_up_sweep;
        int rel, ti, ri, ti2;
        mem[SA] = 8'h45; mem[SA+1] = 8'h59; mem[SA+2] = 8'h23;
        log_q.delete();
        rel = cyc;
        rst = 1'b0;
        wait_ev(2, 1, 300, ti);
        n_cmp++; if (ti < 0) begin n_err++; $display("FAIL pwr_valid got none need time_valid"); end
        else begin
            n_cmp++; if (time_out !== 24'h235945) begin n_err++; $display("FAIL pwr_time_out got %h need 235945", time_out); end
            n_cmp++; if (!sweep_ok(0, ti)) begin n_err++; $display("FAIL pwr_read_seq got bad sequence need addr 0,1,2"); end
            ri = find_ev(0, 1);
            n_cmp++; if (ri < 0 || log_q[ri].cyc - rel > 3) begin n_err++; $display("FAIL pwr_first_read got late/none need within 3 cycles"); end
            wait_ev(0, NR + 1, PC + 60, ri);
            n_cmp++; if (ri < 0 || log_q[ri].cyc - log_q[ti].cyc < PC || log_q[ri].cyc - log_q[ti].cyc > PC + 4) begin
                n_err++; $display("FAIL pwr_poll_gap got %0d need %0d..%0d", (ri < 0) ? -1 : log_q[ri].cyc - log_q[ti].cyc, PC, PC + 4); end
            wait_ev(2, 2, 200, ti2);
            n_cmp++; if (ti2 < 0 || time_out !== model_time()) begin n_err++; $display("FAIL pwr_second got %h need %h", time_out, model_time()); end
        end
    endtask

    task automatic test_poll_random;
        int ti;
        repeat (3) begin
            for (int k = 0; k < NR; k++) mem[(SA + k) % AMOD] = DW'($urandom);
            log_q.delete();
            wait_ev(2, 1, PC + 150, ti);
            n_cmp++; if (ti < 0 || time_out !== model_time()) begin n_err++; $display("FAIL poll_rand got %h need %h", time_out, model_time()); end
        end
    endtask

    task automatic test_set_burst;
        int ti, fi;
        logic [NR*DW-1:0] d;
        for (int r = 0; r < 2; r++) begin
            d = (r == 0) ? 24'h120000 : NR*DW'($urandom);
            log_q.delete();
            set_data = d; set_req = 1'b1;
            @(negedge clk); set_req = 1'b0;
            n_cmp++; if (set_busy !== 1'b1) begin n_err++; $display("FAIL set_busy_rise got %b need 1", set_busy); end
            for (int c = 0; c < 300 && set_busy; c++) @(negedge clk);
            n_cmp++; if (set_busy !== 1'b0) begin n_err++; $display("FAIL set_busy_fall got %b need 0", set_busy); end
            fi = log_q.size();
            n_cmp++; if (!burst_ok(0, fi, d)) begin n_err++; $display("FAIL set_burst got bad writes need data %h", d); end
            wait_ev(2, 1, 60, ti);
            n_cmp++; if (ti < 0 || time_out !== d || !sweep_ok(0, ti)) begin
                n_err++; $display("FAIL set_readback got %h need %h immediately", time_out, d); end
        end
    endtask

    task automatic test_set_during_sweep;
        int ri, ti, ti2, wi;
        logic [NR*DW-1:0] pre, d1, d2;
        log_q.delete();
        wait_ev(0, 2, PC + 60, ri);
        n_cmp++; if (ri < 0) begin n_err++; $display("FAIL mid_set_sweep got none need second read"); end
        pre = model_time();
        d1 = NR*DW'($urandom);
        if (d1 == pre) d1 = ~pre;
        d2 = ~d1;
        set_data = d1; set_req = 1'b1;
        @(negedge clk); set_req = 1'b0;
        repeat (2) @(negedge clk);
        set_data = d2; set_req = 1'b1;
        @(negedge clk); set_req = 1'b0;
        n_cmp++; if (set_busy !== 1'b1) begin n_err++; $display("FAIL mid_set_busy got %b need 1", set_busy); end
        wait_ev(2, 1, 80, ti);
        n_cmp++; if (ti < 0 || time_out !== pre) begin n_err++; $display("FAIL mid_set_publish got %h need %h", time_out, pre); end
        wi = find_ev(1, 1);
        n_cmp++; if (ti < 0 || (wi >= 0 && wi < ti)) begin n_err++; $display("FAIL mid_set_order got write at %0d need after publish %0d", wi, ti); end
        for (int c = 0; c < 300 && set_busy; c++) @(negedge clk);
        n_cmp++; if (!burst_ok(0, log_q.size(), d1)) begin n_err++; $display("FAIL mid_set_burst got bad writes need data %h", d1); end
        wait_ev(2, 2, 80, ti2);
        n_cmp++; if (ti2 < 0 || time_out !== d1) begin n_err++; $display("FAIL mid_set_readback got %h need %h", time_out, d1); end
    endtask

    task automatic test_timeout;
        int ec, ri, lsz, ti;
        logic [NR*DW-1:0] prev;
        prev = time_out;
        log_q.delete();
        hang_addr = (SA + 1) % AMOD;
        hang_en = 1'b1;
        for (int c = 0; c < PC + TO + 200 && timeout_err !== 1'b1; c++) @(negedge clk);
        ec = cyc;
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err got %b need 1", timeout_err); end
        n_cmp++; if (find_ev(2, 1) >= 0) begin n_err++; $display("FAIL to_no_valid got time_valid need none"); end
        n_cmp++; if (time_out !== prev) begin n_err++; $display("FAIL to_hold got %h need %h", time_out, prev); end
        ri = find_ev(0, 2);
        n_cmp++; if (ri < 0 || ec - log_q[ri].cyc < TO || ec - log_q[ri].cyc > TO + 3) begin
            n_err++; $display("FAIL to_latency got %0d need %0d..%0d", (ri < 0) ? -1 : ec - log_q[ri].cyc, TO, TO + 3); end
        hang_en = 1'b0;
        lsz = log_q.size();
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear got %b need 0", timeout_err); end
        wait_ev(2, 1, PC + 120, ti);
        n_cmp++; if (ti < 0 || time_out !== model_time() || !sweep_ok(lsz, ti) || log_q[lsz].kind != 0) begin
            n_err++; $display("FAIL to_recover got %h need %h", time_out, model_time()); end
    endtask

    task automatic test_reset_mid_read;
        int ri, ti, rel;
        log_q.delete();
        wait_ev(0, 2, PC + 60, ri);
        n_cmp++; if (ri < 0) begin n_err++; $display("FAIL rst_mid_sweep got none need second read"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({time_out, time_valid, set_busy, timeout_err, i2c_wr_en, i2c_re_en, i2c_addr, i2c_wdata} !== '0) begin
            n_err++; $display("FAIL rst_async got out=%h addr=%h need all 0", time_out, i2c_addr); end
        for (int k = 0; k < NR; k++) mem[(SA + k) % AMOD] = DW'($urandom);
        repeat (2) @(negedge clk);
        log_q.delete();
        rel = cyc;
        rst = 1'b0;
        wait_ev(2, 1, 200, ti);
        n_cmp++; if (ti < 0 || time_out !== model_time()) begin n_err++; $display("FAIL rst_resweep got %h need %h", time_out, model_time()); end
        n_cmp++; if (ti < 0 || !sweep_ok(0, ti) || log_q[0].cyc - rel > 3) begin n_err++; $display("FAIL rst_resweep_seq got bad sequence need fresh sweep from addr 0"); end
    endtask

`ifdef RTC_BCD_CHECK_EN
    task automatic test_bcd;
        int bi, ti;
        logic [NR*DW-1:0] prev;
        prev = time_out;
        mem[(SA + 1) % AMOD] = 8'h5A;
        log_q.delete();
        wait_ev(3, 1, PC + 120, bi);
        n_cmp++; if (bi < 0) begin n_err++; $display("FAIL bcd_err got none need pulse"); end
        n_cmp++; if (find_ev(2, 1) >= 0 || time_out !== prev) begin n_err++; $display("FAIL bcd_suppress got %h need %h", time_out, prev); end
        mem[SA] = 8'h80; mem[(SA + 1) % AMOD] = 8'h59;
        log_q.delete();
        wait_ev(2, 1, PC + 120, ti);
        n_cmp++; if (ti < 0 || time_out !== model_time() || find_ev(3, 1) >= 0) begin
            n_err++; $display("FAIL bcd_ch_bit got %h need %h", time_out, model_time()); end
    endtask
`endif

    initial begin
        for (int i = 0; i < AMOD; i++) mem[i] = '0;
        test_reset();
        test_power_up_sweep();
        test_poll_random();
        test_set_burst();
        test_set_during_sweep();
        test_timeout();
        test_reset_mid_read();
`ifdef RTC_BCD_CHECK_EN
        test_bcd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_reg_poller.md
Name: rtc_reg_poller

Overview:
- Parametrised successor to the fixed-function RTC top: sequences I2C register transactions against an RTC device through the existing IIC_COR wr_en/re_en/done handshake.
- Periodically sweeps NUM_REGS consecutive registers starting at START_ADDR, buffers them, and publishes the whole set atomically with a valid strobe.
- Adds a host-initiated time-set burst write, a transaction timeout with sticky error, and a programmable poll interval.
- Sits between application logic (display/BCD consumers) and the IIC_COR instance.

Parameters:
- NUM_REGS, 3, number of consecutive RTC registers per sweep (1..8).
- ADDR_W, 13, register address width, matching IIC_COR addr_se_reg.
- DATA_W, 8, register data width.
- START_ADDR, 0, first register address of the sweep and of the set burst.
- POLL_CYC, 100000, idle clk cycles between end of one sweep and start of the next (>=1).
- TIMEOUT_CYC, 1000000, max clk cycles waiting for completion of one transaction.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- set_req  in  1  single-cycle pulse: write set_data to the RTC
- set_data  in  NUM_REGS*DATA_W  register values; reg k at bits [k*DATA_W +: DATA_W]
- set_busy  out  1  high from set_req acceptance until the set burst completes or aborts
- time_out  out  NUM_REGS*DATA_W  last published register set, same packing as set_data
- time_valid  out  1  one-cycle pulse when time_out updates
- timeout_err  out  1  sticky; set on any transaction timeout
- err_clr  in  1  clears timeout_err
- i2c_addr  out  ADDR_W  register address to IIC_COR
- i2c_wr_en  out  1  one-cycle write request
- i2c_re_en  out  1  one-cycle read request
- i2c_wdata  out  DATA_W  write data
- i2c_rdata  in  DATA_W  read data, valid at completion
- i2c_done  in  1  completion level from IIC_COR

Behaviour:
- Reset values: all outputs 0; FSM in POLL_WAIT with timer preloaded to 0, so the first sweep starts on the first cycle after rst deasserts. Reset mid-transaction abandons it; no request is reissued.
- Completion: i2c_done passes through two flops; a rising edge on the delayed signal (done_evt) marks completion.
- Request: i2c_wr_en/i2c_re_en high exactly one cycle. i2c_addr/i2c_wdata are valid that cycle and held until done_evt.
- FSM states and transitions:
  - POLL_WAIT: decrement timer. A pending set goes to SET_ISSUE with index 0. Otherwise, timer==0 goes to RD_ISSUE with index 0.
  - RD_ISSUE: addr=START_ADDR+idx; pulse re_en; go to RD_WAIT.
  - RD_WAIT: on done_evt store i2c_rdata into shadow[idx]. If idx==NUM_REGS-1 go to PUBLISH, else idx++ and go to RD_ISSUE.
  - PUBLISH: time_out<=shadow; pulse time_valid; reload timer=POLL_CYC-1; go to POLL_WAIT.
  - SET_ISSUE: addr=START_ADDR+idx, wdata=latched set_data[idx]; pulse wr_en; go to SET_WAIT.
  - SET_WAIT: on done_evt, if last index clear set_busy and go to RD_ISSUE (immediate readback), else idx++ and go to SET_ISSUE.
- set_req handling: accepted in any state when set_busy==0. set_data is latched and set_busy rises the next cycle. A set request arriving mid-sweep waits until that sweep publishes. set_req while set_busy==1 is ignored.
- Timeout: a cycle counter runs in RD_WAIT/SET_WAIT and resets at each issue. Reaching TIMEOUT_CYC sets timeout_err, discards the shadow (no publish), clears set_busy, reloads the poll timer, and goes to POLL_WAIT.
- err_clr: clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- Address arithmetic: START_ADDR+idx computed in ADDR_W bits and wraps modulo 2^ADDR_W.

Optional Feature:
- Macro RTC_BCD_CHECK_EN.
- Defined: in PUBLISH, every nibble of every shadow register is checked (bit 7 of register 0, the clock-halt bit, is masked). Any nibble >9 suppresses the publish: time_out holds, no time_valid, and a one-cycle bcd_err output pulses.
- Not defined: data is published raw and the bcd_err port is absent.

Decomposition:
- Package rtc_pkg: FSM state encoding, the default device address 7'b1101000, and a CH_BIT_POS=7 constant.
- One sub-module, rtc_done_sync: the two-flop delay plus rising-edge detector producing done_evt.
- Counters, shadow buffer and FSM stay in rtc_reg_poller.

Test Plan:
- Power-up sweep: release rst; the model returns 0x45, 0x59, 0x23 for addr 0..2 -> three re_en pulses at addr 0,1,2, then time_out=0x235945 and one time_valid; next re_en no earlier than POLL_CYC cycles later.
- Set burst: pulse set_req with set_data=0x120000 while idle -> set_busy=1; wr_en at addr 0,1,2 with wdata 0x00, 0x00, 0x12; set_busy falls; readback sweep follows immediately.
- Set during sweep: set_req asserted at the second re_en -> sweep completes and publishes first; the write burst starts next; a second set_req while busy is ignored.
- Timeout: the model never raises done on addr 1 -> after TIMEOUT_CYC, timeout_err=1, no time_valid, time_out unchanged; err_clr clears it; the next sweep succeeds.
- Reset mid-read: assert rst during RD_WAIT -> all outputs 0 asynchronously; after release a fresh sweep starts at addr 0.
- With RTC_BCD_CHECK_EN defined: the model returns 0x5A for minutes -> bcd_err pulses, no time_valid. The value 0x80 in register 0 publishes normally.
